// File: rtl/dc_tagbank_ways.sv
// -----------------------------------------------------------------------------
// dc_tagbank_ways
//
// Set-associative L1 data-cache tag bank. Each entry holds a tag, a 3-bit
// coherence state and an LRU age. A core request looks up every way of one set
// in a single cycle. It reports hit, hit way, the next state and a replacement
// victim one cycle later. In the same edge it commits any state change and LRU
// update. The fill port installs lines from the L2 miss handler. A fill always
// wins the port, and a request is retried in that cycle.
//
// Optional feature: define DC_TAGBANK_PARITY_EN to keep an even-parity bit per
// entry over {tag, state}. A corrupted way never hits and is the preferred
// victim. Without the macro, ack_perr is tied low.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   req_valid/req_retry  core request handshake (accept = valid & !retry)
//   req_type/set/tag     operation code, set index, compare tag
//   fill_*               line install (set, way, tag, state), never stalls
//   ack_valid/ack_retry  lookup result handshake; the result holds while stalled
//   ack_hit/way/state    hit flag, hit way and the state written for that line
//   ack_victim           replacement way for the looked-up set
//   ack_perr             parity mismatch seen during the lookup
// -----------------------------------------------------------------------------
package dc_tagbank_pkg;
    localparam int REQ_BITS = 5;

    // Coherence state codes
    localparam logic [2:0] DC_I  = 3'd0;
    localparam logic [2:0] DC_S  = 3'd1;
    localparam logic [2:0] DC_E  = 3'd2;
    localparam logic [2:0] DC_M  = 3'd3;
    localparam logic [2:0] DC_US = 3'd4;
    localparam logic [2:0] DC_UM = 3'd5;

    // Core operation codes
    localparam logic [REQ_BITS-1:0] CORE_LOP_L8U     = 5'h00;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L8S     = 5'h01;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L16U    = 5'h02;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L16S    = 5'h03;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L32U    = 5'h04;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L32S    = 5'h05;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L64U    = 5'h06;
    localparam logic [REQ_BITS-1:0] CORE_LOP_L128U   = 5'h07;
    localparam logic [REQ_BITS-1:0] CORE_SOP_S64     = 5'h0B;
    localparam logic [REQ_BITS-1:0] CORE_MOP_BEGIN   = 5'h10;
    localparam logic [REQ_BITS-1:0] CORE_MOP_COMMIT  = 5'h11;
    localparam logic [REQ_BITS-1:0] CORE_MOP_CSYNC   = 5'h12;
    localparam logic [REQ_BITS-1:0] CORE_MOP_KILL    = 5'h13;
    localparam logic [REQ_BITS-1:0] CORE_MOP_RESTART = 5'h14;
endpackage

module dc_tagbank_ways
    import dc_tagbank_pkg::*;
#(
    parameter  int Ways    = 4,
    parameter  int Sets    = 32,
    parameter  int TagBits = 18,
    localparam int WAY_W   = $clog2(Ways),
    localparam int SET_W   = $clog2(Sets)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_retry,
    input  logic [REQ_BITS-1:0] req_type,
    input  logic [SET_W-1:0]    req_set,
    input  logic [TagBits-1:0]  req_tag,
    input  logic                fill_valid,
    input  logic [SET_W-1:0]    fill_set,
    input  logic [WAY_W-1:0]    fill_way,
    input  logic [TagBits-1:0]  fill_tag,
    input  logic [2:0]          fill_state,
    output logic                ack_valid,
    input  logic                ack_retry,
    output logic                ack_hit,
    output logic [WAY_W-1:0]    ack_way,
    output logic [2:0]          ack_state,
    output logic [WAY_W-1:0]    ack_victim,
    output logic                ack_perr
);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [TagBits-1:0] tag_q   [Sets][Ways];
    logic [2:0]         state_q [Sets][Ways];
    logic [WAY_W-1:0]   age_q   [Sets][Ways];
`ifdef DC_TAGBANK_PARITY_EN
    logic               par_q   [Sets][Ways];
`endif

    // Next state of a hit line for a given operation.
    function automatic logic [2:0] op_next_state(input logic [REQ_BITS-1:0] op,
                                                 input logic [2:0]          cur);
        logic [2:0] nxt;
        nxt = cur;
        case (op)
            CORE_MOP_BEGIN:                  if (cur == DC_UM) nxt = DC_US;
            CORE_MOP_COMMIT, CORE_MOP_CSYNC: if (cur == DC_US) nxt = DC_S;
            CORE_MOP_KILL, CORE_MOP_RESTART: nxt = DC_I;
            default:                         nxt = cur;
        endcase
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic accept;

    assign req_retry = fill_valid | (ack_valid & ack_retry);
    assign accept    = req_valid & ~req_retry;

    // -------------------------------------------------------------------------
    // Lookup of all ways in req_set
    // -------------------------------------------------------------------------
    logic [Ways-1:0]  way_match, way_inv, way_bad;
    logic             lk_hit, lk_perr;
    logic [WAY_W-1:0] lk_way, lk_victim;
    logic [WAY_W-1:0] first_inv, first_bad, oldest;
    logic [2:0]       lk_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        way_match = '0;
        way_inv   = '0;
        way_bad   = '0;
        for (int w = 0; w < Ways; w++) begin
            way_inv[w] = (state_q[req_set][w] == DC_I);
`ifdef DC_TAGBANK_PARITY_EN
            // Tags are not reset, so parity is only meaningful on valid lines.
            way_bad[w] = ~way_inv[w] &&
                         (par_q[req_set][w] != ^{tag_q[req_set][w], state_q[req_set][w]});
`endif
            way_match[w] = (tag_q[req_set][w] == req_tag) && ~way_inv[w] && ~way_bad[w];
        end
    end

    // Descending scans leave the lowest-numbered candidate in each selector.
    always_comb begin
        lk_way    = '0;
        first_inv = '0;
        first_bad = '0;
        oldest    = '0;
        for (int w = Ways - 1; w >= 0; w--) begin
            if (way_match[w]) lk_way = WAY_W'(w);
            if (way_inv[w])   first_inv = WAY_W'(w);
            if (way_bad[w])   first_bad = WAY_W'(w);
            if (age_q[req_set][w] == WAY_W'(Ways - 1)) oldest = WAY_W'(w);
        end
        lk_hit  = |way_match;
        lk_perr = |way_bad;
        if (|way_bad)      lk_victim = first_bad;
        else if (|way_inv) lk_victim = first_inv;
        else               lk_victim = oldest;
        lk_next = op_next_state(req_type, state_q[req_set][lk_way]);
    end

    // -------------------------------------------------------------------------
    // Array update: a fill or a hitting request touches exactly one way.
    // Both cannot happen together because a fill retries the request.
    // -------------------------------------------------------------------------
    logic             upd_en;
    logic [SET_W-1:0] upd_set;
    logic [WAY_W-1:0] upd_way;
    logic [2:0]       upd_state;
    logic [WAY_W-1:0] used_age;

    always_comb begin
        upd_en    = fill_valid | (accept & lk_hit);
        upd_set   = fill_valid ? fill_set   : req_set;
        upd_way   = fill_valid ? fill_way   : lk_way;
        upd_state = fill_valid ? fill_state : lk_next;
        used_age  = age_q[upd_set][upd_way];
    end

    // State and LRU ages reset to an empty set with ages 0..Ways-1 in way order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < Sets; s++) begin
                for (int w = 0; w < Ways; w++) begin
                    state_q[s][w] <= DC_I;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            state_q[upd_set][upd_way] <= upd_state;
            // The used way becomes youngest. Ways younger than it age by one,
            // which keeps the ages of a set a permutation of 0..Ways-1.
            for (int w = 0; w < Ways; w++) begin
                if (WAY_W'(w) == upd_way)
                    age_q[upd_set][w] <= '0;
                else if (age_q[upd_set][w] < used_age)
                    age_q[upd_set][w] <= age_q[upd_set][w] + WAY_W'(1);
            end
        end
    end

    // NOTE: the tag array has no reset. Every line starts in I, so its tag is
    // never compared before a fill writes it.
    always_ff @(posedge clk) begin
        if (fill_valid)
            tag_q[fill_set][fill_way] <= fill_tag;
`ifdef DC_TAGBANK_PARITY_EN
        if (upd_en)
            par_q[upd_set][upd_way] <= ^{(fill_valid ? fill_tag : tag_q[req_set][lk_way]), upd_state};
`endif
    end

    // -------------------------------------------------------------------------
    // Ack register: loads on accept, drops once consumed, otherwise holds.
    // -------------------------------------------------------------------------
`ifdef DC_TAGBANK_PARITY_EN
    logic ack_perr_q;
    assign ack_perr = ack_perr_q;
`else
    assign ack_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_valid  <= 1'b0;
            ack_hit    <= 1'b0;
            ack_way    <= '0;
            ack_state  <= DC_I;
            ack_victim <= '0;
`ifdef DC_TAGBANK_PARITY_EN
            ack_perr_q <= 1'b0;
`endif
        end else if (accept) begin
            ack_valid  <= 1'b1;
            ack_hit    <= lk_hit;
            ack_way    <= lk_hit ? lk_way  : '0;
            ack_state  <= lk_hit ? lk_next : DC_I;
            ack_victim <= lk_victim;
`ifdef DC_TAGBANK_PARITY_EN
            ack_perr_q <= lk_perr;
`endif
        end else if (ack_valid && !ack_retry) begin
            ack_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dc_tagbank_ways.sv
// -----------------------------------------------------------------------------
// tb_dc_tagbank_ways
//
// Scoreboard bench for dc_tagbank_ways. The stimulus process applies directed
// and random traffic. It predicts each accepted lookup with a reference model
// that tracks recency with timestamps and queues the expected ack. An
// independent monitor compares the presented ack against the queue head on
// every falling edge.
// -----------------------------------------------------------------------------
module tb_dc_tagbank_ways;
    import dc_tagbank_pkg::*;

    localparam int Ways    = 4;
    localparam int Sets    = 32;
    localparam int TagBits = 18;
    localparam int WAY_W   = $clog2(Ways);
    localparam int SET_W   = $clog2(Sets);

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_retry;
    logic [REQ_BITS-1:0] req_type;
    logic [SET_W-1:0]    req_set;
    logic [TagBits-1:0]  req_tag;
    logic                fill_valid;
    logic [SET_W-1:0]    fill_set;
    logic [WAY_W-1:0]    fill_way;
    logic [TagBits-1:0]  fill_tag;
    logic [2:0]          fill_state;
    logic                ack_valid;
    logic                ack_retry;
    logic                ack_hit;
    logic [WAY_W-1:0]    ack_way;
    logic [2:0]          ack_state;
    logic [WAY_W-1:0]    ack_victim;
    logic                ack_perr;

    dc_tagbank_ways #(.Ways(Ways), .Sets(Sets), .TagBits(TagBits)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_retry  (req_retry),
        .req_type   (req_type),
        .req_set    (req_set),
        .req_tag    (req_tag),
        .fill_valid (fill_valid),
        .fill_set   (fill_set),
        .fill_way   (fill_way),
        .fill_tag   (fill_tag),
        .fill_state (fill_state),
        .ack_valid  (ack_valid),
        .ack_retry  (ack_retry),
        .ack_hit    (ack_hit),
        .ack_way    (ack_way),
        .ack_state  (ack_state),
        .ack_victim (ack_victim),
        .ack_perr   (ack_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard and counters
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic [2:0]       st;
        logic [WAY_W-1:0] victim;
        logic             perr;
    } ack_t;

    ack_t sb_q[$];
    bit   pend;          // model: an ack is being presented
    int   vectors;
    int   miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: per-line tag/state, plus a last-use timestamp per way.
    // The LRU way is the one with the oldest timestamp.
    // -------------------------------------------------------------------------
    logic [TagBits-1:0] m_tag   [Sets][Ways];
    logic [2:0]         m_state [Sets][Ways];
    int                 m_last  [Sets][Ways];
    bit                 m_bad   [Sets][Ways];
    int                 stamp;

    task automatic model_reset();
        for (int s = 0; s < Sets; s++)
            for (int w = 0; w < Ways; w++) begin
                m_state[s][w] = DC_I;
                m_last[s][w]  = -w;
                m_bad[s][w]   = 1'b0;
            end
        stamp = 0;
    endtask

    task automatic touch(input int s, input int w);
        stamp++;
        m_last[s][w] = stamp;
    endtask

    function automatic logic [2:0] model_next(input logic [REQ_BITS-1:0] op, input logic [2:0] cur);
        if (op == CORE_MOP_KILL || op == CORE_MOP_RESTART) return DC_I;
        if (op == CORE_MOP_BEGIN && cur == DC_UM) return DC_US;
        if ((op == CORE_MOP_COMMIT || op == CORE_MOP_CSYNC) && cur == DC_US) return DC_S;
        return cur;
    endfunction

    task automatic model_access(input logic [REQ_BITS-1:0] op, input int s,
                                input logic [TagBits-1:0] tag, output ack_t a);
        int hw, bad_w, inv_w, lru_w;
        hw = -1; bad_w = -1; inv_w = -1; lru_w = 0;
        for (int w = 0; w < Ways; w++) begin
            if (m_state[s][w] != DC_I && m_bad[s][w]) begin
                if (bad_w < 0) bad_w = w;
            end else if (m_state[s][w] != DC_I && m_tag[s][w] == tag) begin
                if (hw < 0) hw = w;
            end
            if (m_state[s][w] == DC_I && inv_w < 0) inv_w = w;
            if (m_last[s][w] < m_last[s][lru_w]) lru_w = w;
        end
        a.perr   = (bad_w >= 0);
        a.victim = WAY_W'(bad_w >= 0 ? bad_w : (inv_w >= 0 ? inv_w : lru_w));
        a.hit    = (hw >= 0);
        a.way    = '0;
        a.st     = DC_I;
        if (hw >= 0) begin
            a.way = WAY_W'(hw);
            a.st  = model_next(op, m_state[s][hw]);
            m_state[s][hw] = a.st;
            touch(s, hw);
        end
    endtask

    task automatic model_fill(input int s, input int w, input logic [TagBits-1:0] tag,
                              input logic [2:0] st);
        m_tag[s][w]   = tag;
        m_state[s][w] = st;
        m_bad[s][w]   = 1'b0;
        touch(s, w);
    endtask

    // -------------------------------------------------------------------------
    // One clock of stimulus: inputs are already driven (just after a rising
    // edge). The model is advanced at the falling edge and the ack-pending flag
    // at the rising edge.
    // -------------------------------------------------------------------------
    task automatic cycle();
        bit   exp_retry, acc;
        ack_t a;
        @(negedge clk);
        exp_retry = fill_valid || (pend && ack_retry);
        acc       = req_valid && !exp_retry;
        check("req_retry", req_retry, exp_retry);
        if (acc) begin
            model_access(req_type, int'(req_set), req_tag, a);
            sb_q.push_back(a);
        end
        if (fill_valid) model_fill(int'(fill_set), int'(fill_way), fill_tag, fill_state);
        @(posedge clk);
        pend = acc || (pend && ack_retry);
        #1;
    endtask

    task automatic do_req(input logic [REQ_BITS-1:0] op, input int s, input logic [TagBits-1:0] t);
        req_valid = 1'b1;
        req_type  = op;
        req_set   = SET_W'(s);
        req_tag   = t;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic do_fill(input int s, input int w, input logic [TagBits-1:0] t, input logic [2:0] st);
        fill_valid = 1'b1;
        fill_set   = SET_W'(s);
        fill_way   = WAY_W'(w);
        fill_tag   = t;
        fill_state = st;
        cycle();
        fill_valid = 1'b0;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        fill_valid = 1'b0;
        cycle();
    endtask

    // -------------------------------------------------------------------------
    // Monitor: compares the presented ack with the oldest expectation.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        check("ack_valid", ack_valid, pend);
        if (pend) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard: ack presented with no expectation at %0t", $time);
            end else begin
                check("ack_hit",    ack_hit,    sb_q[0].hit);
                check("ack_way",    ack_way,    sb_q[0].way);
                check("ack_state",  ack_state,  sb_q[0].st);
                check("ack_victim", ack_victim, sb_q[0].victim);
                check("ack_perr",   ack_perr,   sb_q[0].perr);
                if (!ack_retry) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [TagBits-1:0]  tag_pool [4] = '{18'h155, 18'h2AA, 18'h3, 18'h3FFFF};
    logic [2:0]          st_pool  [6] = '{DC_I, DC_S, DC_E, DC_M, DC_US, DC_UM};
    logic [REQ_BITS-1:0] op_pool  [8] = '{CORE_LOP_L8U, CORE_LOP_L64U, CORE_MOP_BEGIN,
                                          CORE_MOP_COMMIT, CORE_MOP_CSYNC, CORE_MOP_KILL,
                                          CORE_MOP_RESTART, CORE_SOP_S64};

    initial begin
        vectors = 0; miscompares = 0; pend = 1'b0;
        reset = 1'b0;
        req_valid = 1'b0; req_type = '0; req_set = '0; req_tag = '0;
        fill_valid = 1'b0; fill_set = '0; fill_way = '0; fill_tag = '0; fill_state = DC_I;
        ack_retry = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_valid",  ack_valid,  0);
        check("rst_ack_hit",    ack_hit,    0);
        check("rst_ack_way",    ack_way,    0);
        check("rst_ack_state",  ack_state,  DC_I);
        check("rst_ack_victim", ack_victim, 0);
        check("rst_ack_perr",   ack_perr,   0);
        reset = 1'b1;
        idle();

        // Lookup in an empty set
        do_req(CORE_LOP_L8U, 3, 18'h155);
        check("empty_hit",    ack_hit,    0);
        check("empty_state",  ack_state,  DC_I);
        check("empty_victim", ack_victim, 0);

        // Fill then hit; next miss still picks the lowest invalid way
        do_fill(3, 2, 18'h155, DC_E);
        do_req(CORE_LOP_L64U, 3, 18'h155);
        check("fill_hit",   ack_hit,   1);
        check("fill_way",   ack_way,   2);
        check("fill_state", ack_state, DC_E);
        do_req(CORE_LOP_L8U, 3, 18'h2AA);
        check("miss_victim_inv", ack_victim, 0);

        // Full set: LRU victim after touching way 0
        for (int w = 0; w < Ways; w++) do_fill(5, w, 18'h10 + TagBits'(w), DC_S);
        do_req(CORE_LOP_L32U, 5, 18'h10);
        check("lru_hit_way", ack_way, 0);
        do_req(CORE_LOP_L32U, 5, 18'h99);
        check("lru_victim", ack_victim, 1);

        // Transactional state walk
        do_fill(7, 1, 18'h3A, DC_UM);
        do_req(CORE_MOP_BEGIN, 7, 18'h3A);
        check("begin_state", ack_state, DC_US);
        do_req(CORE_MOP_COMMIT, 7, 18'h3A);
        check("commit_state", ack_state, DC_S);
        do_req(CORE_MOP_KILL, 7, 18'h3A);
        check("kill_state", ack_state, DC_I);
        do_req(CORE_LOP_L8U, 7, 18'h3A);
        check("after_kill_hit", ack_hit, 0);

        // Held ack under ack_retry with a request waiting
        do_req(CORE_LOP_L8U, 5, 18'h11);
        ack_retry = 1'b1;
        req_valid = 1'b1; req_type = CORE_LOP_L16U; req_set = SET_W'(5); req_tag = 18'h12;
        repeat (3) begin
            cycle();
            check("hold_req_retry", req_retry, 1);
        end
        ack_retry = 1'b0;
        cycle();
        check("reload_valid", ack_valid, 1);
        check("reload_way",   ack_way,   2);
        idle();

`ifdef DC_TAGBANK_PARITY_EN
        // Corrupt one stored tag bit behind the bank's back
        do_fill(1, 0, 18'h77, DC_E);
        dut.tag_q[1][0] <= dut.tag_q[1][0] ^ 18'h1;
        m_bad[1][0] = 1'b1;
        do_req(CORE_LOP_L8U, 1, 18'h77);
        check("perr_hit",    ack_hit,    0);
        check("perr_flag",   ack_perr,   1);
        check("perr_victim", ack_victim, 0);
`endif

        // Reset with an ack pending discards it and empties every set
        do_fill(9, 0, 18'h44, DC_M);
        do_req(CORE_LOP_L8U, 9, 18'h44);
        reset = 1'b0;
        pend  = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        check("midrst_valid", ack_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        do_req(CORE_LOP_L8U, 9, 18'h44);
        check("midrst_miss", ack_hit, 0);

        // Random traffic over a few sets with a small tag pool
        for (int i = 0; i < 800; i++) begin
            fill_valid = ($urandom_range(0, 9) < 2);
            fill_set   = SET_W'($urandom_range(0, 3));
            fill_way   = WAY_W'($urandom_range(0, Ways - 1));
            fill_tag   = tag_pool[$urandom_range(0, 3)];
            fill_state = st_pool[$urandom_range(0, 5)];
            req_valid  = ($urandom_range(0, 3) != 0);
            req_type   = op_pool[$urandom_range(0, 7)];
            req_set    = SET_W'($urandom_range(0, 3));
            req_tag    = tag_pool[$urandom_range(0, 3)];
            ack_retry  = ($urandom_range(0, 3) == 0);
            cycle();
        end

        // Drain
        ack_retry = 1'b0;
        repeat (4) idle();
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dc_tagbank_ways.md
# dc_tagbank_ways

Parametrised, set-associative L1 data-cache tag bank. It stores tag, coherence state and per-way LRU age for every line. Each core request gets a lookup with hit/way/victim reporting, and the bank updates the line state as the operation requires. It sits between the DC request pipeline (core side) and the DC data banks / L2 miss handler (fill side). It replaces the single-way tag bank, adding associativity, replacement tracking and a fill path.

## Interface
Parameters:
- Ways, 4, associativity; power of two, 2..16
- Sets, 32, sets per bank; power of two
- TagBits, 18, stored tag width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request valid
- req_retry  out  1  request not accepted this cycle
- req_type  in  REQ_BITS  operation code, `CORE_LOP_*` / `CORE_MOP_*` from scmem.vh
- req_set  in  log2(Sets)  set index
- req_tag  in  TagBits  tag to compare
- fill_valid  in  1  install line (no retry; always accepted)
- fill_set  in  log2(Sets)  set to install into
- fill_way  in  log2(Ways)  way to install into
- fill_tag  in  TagBits  tag to install
- fill_state  in  3  state to install
- ack_valid  out  1  lookup result valid
- ack_retry  in  1  consumer stalls result
- ack_hit  out  1  tag match on a non-I way
- ack_way  out  log2(Ways)  hit way (0 on miss)
- ack_state  out  3  next state written for the hit line (`I` on miss)
- ack_victim  out  log2(Ways)  replacement way for this set
- ack_perr  out  1  parity error seen (see Configuration)

## Operation
- Storage is in flops, with one entry per (set, way): tag, 3-bit state, age of log2(Ways) bits.
- State encodings are the DC_define.v codes: `I`, `S`, `E`, `M`, `US`, `UM`.
- A request is accepted when req_valid=1 and req_retry=0.
  - req_retry = fill_valid | (ack_valid & ack_retry).
- On accept, the bank reads all ways of req_set.
  - hit = tag equal and state ≠ `I`.
  - If several ways match, the lowest-numbered way wins.
- Next state on hit:
  - Loads (all `CORE_LOP_L*`): unchanged.
  - `CORE_MOP_BEGIN`: `UM`→`US`; otherwise unchanged.
  - `CORE_MOP_COMMIT` and `CORE_MOP_CSYNC`: `US`→`S`; otherwise unchanged.
  - `CORE_MOP_KILL` and `CORE_MOP_RESTART`: →`I`.
  - Any other code: unchanged.
- On a miss, no array write occurs.
- LRU update on hit, or on any fill (the used way):
  - Every way whose age is below the used way's old age increments.
  - The used way's age becomes 0.
  - Ages within a set always form a permutation of 0..Ways-1.
- Victim selection: the lowest-numbered `I` way; if there is none, the way with age Ways-1.
- Fill writes tag, state and age at fill_set/fill_way, and blocks a request in the same cycle.

## Timing
- Reset (reset=0, asynchronous):
  - All states → `I`; age[w] = w in every set.
  - ack_valid, ack_hit, ack_way, ack_victim and ack_perr → 0; ack_state → `I`.
  - Tags are not reset.
  - Reset mid-operation discards any pending ack.
- Latency is 1 cycle: a request accepted at edge N presents its ack after edge N.
- The state and LRU write for that request commits at the same edge N.
  - A back-to-back request to the same set at N+1 sees the updated state.
- Ack outputs hold stable while ack_valid=1 and ack_retry=1.
- ack_valid clears after a cycle with ack_retry=0 and no new accept.
  - If a new request is accepted in that cycle, the ack reloads instead.
- A fill at edge N is visible to a lookup accepted at N+1.
- Fill and pending ack: a fill during a held ack does not alter the held ack values.

## Configuration
- `DC_TAGBANK_PARITY_EN` defined:
  - Each entry stores an even-parity bit over {tag, state}, written on every fill or state update.
  - On lookup, a way with a parity mismatch is treated as non-matching, and ack_perr=1 for that ack.
  - A mismatching way is preferred as victim, ahead of `I` ways.
- `DC_TAGBANK_PARITY_EN` undefined: no parity storage, and ack_perr is tied to 0.

## Test plan
- Reset, then load lookup set 3 tag 0x155 → ack_hit=0, ack_state=`I`, ack_victim=0.
- Fill set 3 way 2 tag 0x155 `E`, then `CORE_LOP_L64U` to the same set/tag → ack_hit=1, ack_way=2, ack_state=`E`. A following miss in set 3 reports ack_victim=0.
- Fill ways 0..3 of set 5 in order, then hit way 0 → a subsequent miss gives ack_victim=1.
- Way in `UM`: `CORE_MOP_BEGIN` gives ack_state=`US`; then `CORE_MOP_COMMIT` gives `S`; then `CORE_MOP_KILL` gives `I`; then a load misses.
- Hold ack_retry=1 for 3 cycles with req_valid=1 → req_retry=1 and the ack stays stable. When ack_retry drops, the next ack appears one cycle after accept.
- With `DC_TAGBANK_PARITY_EN`, force a tag bit flip in set 1 way 0 → lookup gives ack_hit=0, ack_perr=1, ack_victim=0.
